// File: rtl/sd_spi_responder.sv
// SPI-mode SD card responder: CMD0/CMD55/ACMD41/CMD17 single-block read from an external byte store.
// Define SD_RESP_CRC16_EN to send CRC16-CCITT after each data block instead of 0xFFFF.
module sd_spi_responder (
  input  logic        iCLK,
  input  logic        Reset,
  input  logic        SD_CLK,
  input  logic        SD_CS,
  input  logic        SD_MOSI,
  output logic        SD_MISO,
  output logic [31:0] oBlockAddr,
  output logic [8:0]  oRdAddr,
  output logic        oRdReq,
  input  logic [7:0]  iRdData,
  output logic        oBusy,
  output logic [5:0]  oLastCmd
);

  typedef enum logic [2:0] {HUNT, CMD_RX, NCR, RESP, GAP, TOKEN, DATA, CRC} state_t;
  state_t state, state_n;

  logic [2:0]  sclk_q;
  logic [1:0]  cs_q, mosi_q;
  logic        cs_hi, rise, fall, byte_done;
  logic [2:0]  bitcnt, bytecnt;
  logic [6:0]  rxsr;
  logic [7:0]  rx_byte, txsr, tx_byte, r1, r1_n, rd_byte;
  logic [5:0]  cmd_idx;
  logic [31:0] arg;
  logic        idle, app, rd_go, idle_n, app_n, go_n;
  logic        load_pend, rd_q, crc_cnt;
`ifdef SD_RESP_CRC16_EN
  logic [15:0] crc;

  function automatic logic [15:0] crc16_upd(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 7; i >= 0; i--)
      r = (r[15] ^ d[i]) ? ({r[14:0], 1'b0} ^ 16'h1021) : {r[14:0], 1'b0};
    return r;
  endfunction
`endif

  // sclk_q[1]/[2] are the synchronized level and its previous value
  always_ff @(posedge iCLK or negedge Reset)
    if (!Reset) begin
      sclk_q <= '0;
      cs_q   <= 2'b11;
      mosi_q <= '0;
    end else begin
      sclk_q <= {sclk_q[1:0], SD_CLK};
      cs_q   <= {cs_q[0], SD_CS};
      mosi_q <= {mosi_q[0], SD_MOSI};
    end

  assign cs_hi     = cs_q[1];
  assign rise      = sclk_q[1] & ~sclk_q[2] & ~cs_hi;
  assign fall      = ~sclk_q[1] & sclk_q[2] & ~cs_hi;
  assign rx_byte   = {rxsr, mosi_q[1]};
  assign byte_done = rise & (bitcnt == 3'd7);
  assign SD_MISO   = txsr[7];
  assign oBusy     = (state != HUNT);

  always_comb begin
    r1_n   = {5'b0, 2'b10, idle};
    idle_n = idle;
    app_n  = 1'b0;
    go_n   = 1'b0;
    case (cmd_idx)
      6'd0:  begin r1_n = 8'h01; idle_n = 1'b1; end
      6'd55: begin r1_n = {7'b0, idle}; app_n = 1'b1; end
      6'd41: if (app) begin r1_n = 8'h00; idle_n = 1'b0; end
      6'd17: begin r1_n = idle ? 8'h05 : 8'h00; go_n = ~idle; end
      default: ;
    endcase
  end

  // Byte presented on the fall after a byte boundary depends on the state just entered
  always_comb begin
    tx_byte = 8'hFF;
    case (state)
      RESP:  tx_byte = r1;
      TOKEN: tx_byte = 8'hFE;
      DATA:  tx_byte = rd_byte;
`ifdef SD_RESP_CRC16_EN
      CRC:   tx_byte = crc_cnt ? crc[7:0] : crc[15:8];
`endif
      default: ;
    endcase
  end

  always_comb begin
    state_n = state;
    if (cs_hi) state_n = HUNT;
    else if (byte_done)
      case (state)
        HUNT:    if (rx_byte[7:6] == 2'b01) state_n = CMD_RX;
        CMD_RX:  if (bytecnt == 3'd5) state_n = NCR;
        NCR:     state_n = RESP;
        RESP:    state_n = rd_go ? GAP : HUNT;
        GAP:     state_n = TOKEN;
        TOKEN:   state_n = DATA;
        DATA:    if (oRdAddr == 9'd511) state_n = CRC;
        CRC:     if (crc_cnt) state_n = HUNT;
        default: state_n = HUNT;
      endcase
  end

  always_ff @(posedge iCLK or negedge Reset)
    if (!Reset) state <= HUNT;
    else        state <= state_n;

  always_ff @(posedge iCLK or negedge Reset)
    if (!Reset) begin
      bitcnt     <= '0;
      bytecnt    <= '0;
      rxsr       <= '0;
      txsr       <= 8'hFF;
      cmd_idx    <= '0;
      arg        <= '0;
      r1         <= 8'hFF;
      idle       <= 1'b1;
      app        <= 1'b0;
      rd_go      <= 1'b0;
      load_pend  <= 1'b0;
      rd_q       <= 1'b0;
      rd_byte    <= '0;
      crc_cnt    <= 1'b0;
      oRdReq     <= 1'b0;
      oRdAddr    <= '0;
      oBlockAddr <= '0;
      oLastCmd   <= '0;
`ifdef SD_RESP_CRC16_EN
      crc        <= '0;
`endif
    end else begin
      oRdReq <= 1'b0;
      rd_q   <= oRdReq;
      if (rd_q) rd_byte <= iRdData;
      if (cs_hi) begin
        bitcnt    <= '0;
        bytecnt   <= '0;
        crc_cnt   <= 1'b0;
        load_pend <= 1'b0;
        txsr      <= 8'hFF;
        oRdAddr   <= '0;
      end else begin
        if (rise) begin
          rxsr   <= rx_byte[6:0];
          bitcnt <= bitcnt + 3'd1;
        end
        if (fall) begin
          if (load_pend) begin
            txsr      <= tx_byte;
            load_pend <= 1'b0;
`ifdef SD_RESP_CRC16_EN
            if (state == DATA) crc <= crc16_upd(crc, tx_byte);
`endif
          end else
            txsr <= {txsr[6:0], 1'b1};
        end
        if (byte_done) begin
          load_pend <= 1'b1;
          case (state)
            HUNT: if (rx_byte[7:6] == 2'b01) begin
              cmd_idx <= rx_byte[5:0];
              bytecnt <= 3'd1;
            end
            CMD_RX: begin
              bytecnt <= bytecnt + 3'd1;
              if (bytecnt != 3'd5) arg <= {arg[23:0], rx_byte};
              else begin
                bytecnt  <= '0;
                oLastCmd <= cmd_idx;
                r1       <= r1_n;
                idle     <= idle_n;
                app      <= app_n;
                rd_go    <= go_n;
                if (go_n) oBlockAddr <= arg;
              end
            end
            TOKEN: begin
              oRdAddr <= '0;
              oRdReq  <= 1'b1;
`ifdef SD_RESP_CRC16_EN
              crc     <= '0;
`endif
            end
            DATA: begin
              oRdAddr <= oRdAddr + 9'd1;
              if (oRdAddr != 9'd511) oRdReq <= 1'b1;
            end
            CRC: crc_cnt <= ~crc_cnt;
            default: ;
          endcase
        end
      end
    end

endmodule

// File: tb/tb_sd_spi_responder.sv
// Bench for sd_spi_responder: host-side SPI driver, MISO byte scoreboard, read-request monitor.
`timescale 1ns/1ps
module tb_sd_spi_responder;
  logic        iCLK = 1'b0, Reset = 1'b0, SD_CLK = 1'b0, SD_CS = 1'b1, SD_MOSI = 1'b1;
  logic        SD_MISO, oRdReq, oBusy;
  logic [31:0] oBlockAddr;
  logic [8:0]  oRdAddr;
  logic [7:0]  iRdData = 8'h00;
  logic [5:0]  oLastCmd;

  int          total = 0, bad = 0, rd_cnt = 0, rd_exp = 0, mnb = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  rtbl[512];
  logic [7:0]  msh = 8'h00;
  bit          mem_k = 1'b0, m_idle = 1'b1, m_app = 1'b0;
  logic [31:0] m_blk = 32'h0;

  sd_spi_responder dut (
    .iCLK(iCLK), .Reset(Reset), .SD_CLK(SD_CLK), .SD_CS(SD_CS), .SD_MOSI(SD_MOSI),
    .SD_MISO(SD_MISO), .oBlockAddr(oBlockAddr), .oRdAddr(oRdAddr), .oRdReq(oRdReq),
    .iRdData(iRdData), .oBusy(oBusy), .oLastCmd(oLastCmd)
  );

  always #5 iCLK = ~iCLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] mem_byte(input logic [31:0] blk, input logic [8:0] a);
    return mem_k ? a[7:0] : (rtbl[a] ^ blk[7:0]);
  endfunction

  // Block store: answers one cycle after each request
  always @(posedge iCLK) if (oRdReq) iRdData <= mem_byte(oBlockAddr, oRdAddr);

  // Monitor: reassemble MISO bytes as the host sees them and score against the queue
  always @(posedge SD_CLK or posedge SD_CS) begin
    if (SD_CS) mnb = 0;
    else if (Reset) begin
      msh = {msh[6:0], SD_MISO};
      mnb++;
      if (mnb == 8) begin
        mnb = 0;
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL miso_extra: got %02h want nothing", msh);
        end else chk("miso_byte", 32'(msh), 32'(exp_q.pop_front()));
      end
    end
  end

  // Read requests must walk the block from 0 upwards within each transfer
  always @(negedge iCLK) begin
    if (!oBusy) rd_exp = 0;
    if (oRdReq) begin
      chk("rd_addr", 32'(oRdAddr), 32'(rd_exp));
      rd_exp++;
      rd_cnt++;
    end
  end

  task automatic xfer(input logic [7:0] mo, input logic [7:0] ex);
    exp_q.push_back(ex);
    for (int i = 7; i >= 0; i--) begin
      SD_MOSI = mo[i];
      #40 SD_CLK = 1'b1;
      #40 SD_CLK = 1'b0;
    end
  endtask

  task automatic model_cmd(input logic [5:0] idx, output logic [7:0] r1, output bit rd);
    rd = 1'b0;
    if (idx == 6'd0) begin r1 = 8'h01; m_idle = 1'b1; end
    else if (idx == 6'd55) r1 = {7'b0, m_idle};
    else if (idx == 6'd41 && m_app) begin r1 = 8'h00; m_idle = 1'b0; end
    else if (idx == 6'd17) begin r1 = m_idle ? 8'h05 : 8'h00; rd = !m_idle; end
    else r1 = m_idle ? 8'h05 : 8'h04;
    m_app = (idx == 6'd55);
  endtask

  // One command; for a read, ndata < 512 stops after that many data bytes (caller aborts)
  task automatic send_cmd(input logic [5:0] idx, input logic [31:0] a, input int ndata);
    logic [7:0]  r1, d;
    logic [15:0] c;
    bit          rd, fb;
    int          rc0, want;
    rc0 = rd_cnt;
    xfer({2'b01, idx}, 8'hFF);
    for (int i = 3; i >= 0; i--) xfer(a[i*8 +: 8], 8'hFF);
    xfer(idx == 6'd0 ? 8'h95 : 8'h01, 8'hFF);
    model_cmd(idx, r1, rd);
    if (rd) m_blk = a;
    xfer(8'hFF, 8'hFF);
    xfer(8'hFF, r1);
    if (rd) begin
      xfer(8'hFF, 8'hFF);
      xfer(8'hFF, 8'hFE);
      c = 16'h0;
      for (int k = 0; k < ndata; k++) begin
        d = mem_byte(a, 9'(k));
        for (int b = 7; b >= 0; b--) begin
          fb = c[15] ^ d[b];
          c = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0);
        end
        xfer(8'hFF, d);
      end
      if (ndata == 512) begin
`ifdef SD_RESP_CRC16_EN
        xfer(8'hFF, c[15:8]);
        xfer(8'hFF, c[7:0]);
`else
        xfer(8'hFF, 8'hFF);
        xfer(8'hFF, 8'hFF);
`endif
        xfer(8'hFF, 8'hFF);
      end
    end else xfer(8'hFF, 8'hFF);
    #80;
    want = !rd ? 0 : (ndata == 512 ? 512 : ndata + 1);
    chk("last_cmd", 32'(oLastCmd), 32'(idx));
    chk("block_addr", oBlockAddr, m_blk);
    chk("rd_req_count", 32'(rd_cnt - rc0), 32'(want));
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_miso"}, 32'(SD_MISO), 32'd1);
    chk({tag, "_busy"}, 32'(oBusy), 32'd0);
    chk({tag, "_rdreq"}, 32'(oRdReq), 32'd0);
    chk({tag, "_rdaddr"}, 32'(oRdAddr), 32'd0);
    chk({tag, "_blkaddr"}, oBlockAddr, 32'd0);
    chk({tag, "_lastcmd"}, 32'(oLastCmd), 32'd0);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: run did not complete, want completion");
    $fatal(1);
  end

  initial begin
    logic [5:0] lst[7];
    lst = '{6'd0, 6'd8, 6'd9, 6'd13, 6'd41, 6'd55, 6'd58};
    for (int i = 0; i < 512; i++) rtbl[i] = 8'($urandom);
    #100;
    chk_reset("reset");
    Reset = 1'b1;
    #100 SD_CS = 1'b0;
    #80;
    send_cmd(6'd0, 32'h0, 0);
    send_cmd(6'd17, $urandom, 0);           // still idle: 0x05, no data
    send_cmd(6'd55, 32'h0, 0);
    send_cmd(6'd41, 32'h0, 0);
    for (int n = 0; n < 8; n++) send_cmd(lst[$urandom_range(6, 0)], $urandom, 0);
    send_cmd(6'd55, 32'h0, 0);
    send_cmd(6'd41, $urandom, 0);
    send_cmd(6'd9, 32'h0, 0);
    mem_k = 1'b1;
    send_cmd(6'd17, 32'h10, 512);
    mem_k = 1'b0;
    send_cmd(6'd17, $urandom, 100);
    SD_CS = 1'b1;
    #40;
    chk("abort_busy", 32'(oBusy), 32'd0);
    chk("abort_miso", 32'(SD_MISO), 32'd1);
    #80 SD_CS = 1'b0;
    #80;
    send_cmd(6'd17, $urandom, 3);
    Reset = 1'b0;
    #1 chk_reset("midreset");
    #9 SD_CS = 1'b1;
    m_idle = 1'b1; m_app = 1'b0; m_blk = 32'h0;
    #100 Reset = 1'b1;
    #100 SD_CS = 1'b0;
    #80;
    send_cmd(6'd0, 32'h0, 0);
    send_cmd(6'd17, $urandom, 0);
    #200;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sd_spi_responder.md
SD_SPI_RESPONDER -- requirements
Module: sd_spi_responder

Interface
REQ-001 iCLK  input  1  system clock, all state on rising edge.
REQ-002 Reset  input  1  asynchronous, active-low reset.
REQ-003 SD_CLK  input  1  SPI clock from host, mode 0, frequency at most iCLK/8.
REQ-004 SD_CS  input  1  chip select, active-low.
REQ-005 SD_MOSI  input  1  host-to-card serial data, MSB first.
REQ-006 SD_MISO  output  1  card-to-host serial data, MSB first.
REQ-007 oBlockAddr  output  32  argument latched from the last accepted CMD17.
REQ-008 oRdAddr  output  9  byte index within the 512-byte block being fetched.
REQ-009 oRdReq  output  1  one-cycle pulse requesting the byte at {oBlockAddr,oRdAddr}.
REQ-010 iRdData  input  8  block byte, valid exactly 1 iCLK after oRdReq.
REQ-011 oBusy  output  1  high whenever state is not HUNT.
REQ-012 oLastCmd  output  6  index of the last complete command frame.

Function
REQ-013 SD_CLK, SD_CS and SD_MOSI SHALL pass through 2-flop synchronizers; SCLK rise/fall SHALL be detected from the synchronized copy.
REQ-014 MOSI SHALL be sampled on each detected rise; MISO SHALL change only on detected falls; txsr[7] drives SD_MISO, shifting left with 1 fill.
REQ-015 States: HUNT, CMD_RX, NCR, RESP, GAP, TOKEN, DATA, CRC.
REQ-016 HUNT: a received byte with bits[7:6]=01 SHALL move to CMD_RX with that byte as frame byte 0; all other bytes ignored.
REQ-017 CMD_RX: collect bytes 1-5 (argument MSB first, then CRC byte, CRC ignored); after byte 5 go to NCR and update oLastCmd.
REQ-018 NCR: transmit one 0xFF byte, then RESP transmits R1.
REQ-019 Internal idle flag (1 after reset) and app flag: CMD0 -> R1=0x01, idle=1; CMD55 -> R1={7'b0,idle}, app=1; ACMD41 (app=1, index 41) -> R1=0x00, idle=0; CMD17 with idle=0 -> R1=0x00; CMD17 with idle=1 -> R1=0x05; any other -> R1=0x04|idle.
REQ-020 app SHALL clear after any command other than CMD55.
REQ-021 After R1, CMD17 with R1=0x00 SHALL proceed GAP (one 0xFF), TOKEN (0xFE), DATA (512 bytes), CRC (2 bytes), then HUNT; all other commands return to HUNT.
REQ-022 Each byte SHALL load into txsr on the fall following the 8th rise of the previous byte; the first NCR byte loads on the fall after the frame's last rise.
REQ-023 oRdReq for byte k SHALL pulse on the iCLK the byte before k is loaded (byte 0 during TOKEN); oRdAddr wraps 511 -> 0, no request after byte 511.
REQ-024 MOSI bytes received outside HUNT/CMD_RX SHALL be ignored.
REQ-025 SD_CS high (synchronized) in any state SHALL abort to HUNT within 1 iCLK, clear bit/byte counters, force SD_MISO=1; idle and app flags kept.
REQ-026 While SD_CS high, SCLK edges SHALL be ignored.

Reset
REQ-027 On Reset low: state=HUNT, SD_MISO=1, txsr=0xFF, oRdReq=0, oRdAddr=0, oBlockAddr=0, oLastCmd=0, oBusy=0, idle=1, app=0, counters=0.
REQ-028 Release SHALL take effect at the next iCLK edge; no SPI activity required.

Configuration
REQ-029 Macro SD_RESP_CRC16_EN defined: the CRC phase SHALL transmit CRC16-CCITT (poly 0x1021, init 0x0000, MSB first) over the 512 data bytes, high byte first.
REQ-030 Macro SD_RESP_CRC16_EN undefined: the CRC phase SHALL transmit 0xFF, 0xFF and no CRC logic exists.

Verification
REQ-031 Reset, CS low, send 40 00 00 00 00 95 then 16 clocks of 0xFF -> MISO 0xFF, 0x01; oLastCmd=0.
REQ-032 After CMD0: CMD55 then ACMD41 (69 40 00 00 00 77) -> R1 0x01 then 0x00; CMD17 now returns 0x00.
REQ-033 CMD17 arg 0x00000010 with memory byte k = k[7:0] -> oBlockAddr=0x10, MISO 0xFF,0x00,0xFF,0xFE,00..FF,00..FF, then CRC bytes (0xFF,0xFF without macro; computed CRC16 with it); oRdReq count=512.
REQ-034 CMD17 with idle=1 -> R1 0x05, no token, no oRdReq.
REQ-035 CS high after 100 data bytes -> state HUNT in ≤1 iCLK after sync, MISO=1; next CMD17 restarts at oRdAddr=0.
REQ-036 Unsupported CMD9 after init -> R1 0x04; Reset asserted mid-DATA -> all outputs at reset values immediately.
